ahb_lite_interconnect: RTL and testbench

//  Parametrised AHB-Lite single-master interconnect: address decoder, data-phase

---
 rtl/ahb_lite_interconnect.sv | 149 ++++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: address decode, data-phase mux and a default slave
// that answers unmapped transfers with a two-cycle ERROR. Optional slave timeout: AHB_IC_TIMEOUT_EN.
module ahb_lite_interconnect #(
   parameter int unsigned NSLV        = 5,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REGION_BITS = 24,
   parameter logic [NSLV*(ADDR_W-REGION_BITS)-1:0] SLV_BASE = {8'h54, 8'h53, 8'h52, 8'h51, 8'h00},
   parameter logic [DATA_W-1:0] DEFAULT_RDATA = 32'hDEADBEEF,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic [ADDR_W-1:0]        HADDR,
   input  logic [1:0]               HTRANS,
   output logic [NSLV-1:0]          HSEL,
   input  logic [NSLV*DATA_W-1:0]   HRDATA_S,
   input  logic [NSLV-1:0]          HREADYOUT_S,
   input  logic [NSLV-1:0]          HRESP_S,
   output logic [DATA_W-1:0]        HRDATA,
   output logic                     HREADY,
   output logic                     HRESP,
   output logic                     TIMEOUT_IRQ
);

   localparam int unsigned TAG_W = ADDR_W - REGION_BITS;
   localparam int unsigned SEL_W = NSLV + 1;
   localparam logic [SEL_W-1:0] DSEL_DEF = SEL_W'(1) << NSLV;

   typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} def_state_e;

   logic [NSLV-1:0]   match_c;
   logic              no_match_c;
   logic [SEL_W-1:0]  dsel_q, dsel_d;
   def_state_e        state_q, state_d;
   logic [DATA_W-1:0] slv_rdata_c;
   logic              slv_ready_c;
   logic              slv_resp_c;
   logic              def_owns_c;
   logic              timeout_hit_c;

   // Region decode; lowest matching index wins, no match leaves HSEL at zero
   always_comb begin
      match_c = '0;
      HSEL    = '0;
      for (int i = 0; i < int'(NSLV); i++)
         match_c[i] = (HADDR[ADDR_W-1:REGION_BITS] == SLV_BASE[i*TAG_W +: TAG_W]);
      for (int i = int'(NSLV) - 1; i >= 0; i--)
         if (match_c[i]) HSEL = NSLV'(1) << i;
      no_match_c = ~|match_c;
   end

   // Data-phase mux from the registered owner
   always_comb begin
      slv_rdata_c = '0;
      slv_ready_c = 1'b0;
      slv_resp_c  = 1'b0;
      for (int i = 0; i < int'(NSLV); i++) begin
         if (dsel_q[i]) begin
            slv_rdata_c = slv_rdata_c | HRDATA_S[i*DATA_W +: DATA_W];
            slv_ready_c = slv_ready_c | HREADYOUT_S[i];
            slv_resp_c  = slv_resp_c | HRESP_S[i];
         end
      end
   end

   // Any non-IDLE default-slave state overrides the owner, which also covers a timed-out slave
   always_comb begin
      def_owns_c = dsel_q[NSLV] || (state_q != ST_IDLE);
      if (state_q != ST_IDLE) begin
         HREADY = (state_q != ST_ERR1);
         HRESP  = 1'b1;
      end else if (dsel_q[NSLV]) begin
         HREADY = 1'b1;
         HRESP  = 1'b0;
      end else begin
         HREADY = slv_ready_c;
         HRESP  = slv_resp_c;
      end
      HRDATA = def_owns_c ? DEFAULT_RDATA : slv_rdata_c;
   end

   always_comb begin
      state_d = ST_IDLE;
      if (state_q == ST_ERR1)
         state_d = ST_ERR2;
      else if (timeout_hit_c)
         state_d = ST_ERR1;
      else if (HREADY && no_match_c && HTRANS[1])
         state_d = ST_ERR1;
      dsel_d = HREADY ? {no_match_c, HSEL} : dsel_q;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         dsel_q  <= DSEL_DEF;
      end else begin
         state_q <= state_d;
         dsel_q  <= dsel_d;
      end
   end

`ifdef AHB_IC_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             dvalid_q, dvalid_d;
   logic             irq_q, irq_d;
   logic             slv_wait_c;

   // Count wait states of a real slave on an active transfer; hitting the limit forces ERR1
   always_comb begin
      slv_wait_c    = dvalid_q && !def_owns_c && !slv_ready_c;
      timeout_hit_c = slv_wait_c && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      dvalid_d      = HREADY ? HTRANS[1] : dvalid_q;
      wait_cnt_d    = wait_cnt_q;
      if (HREADY || timeout_hit_c)
         wait_cnt_d = '0;
      else if (slv_wait_c)
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      irq_d = timeout_hit_c;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt_q <= '0;
         dvalid_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         dvalid_q   <= dvalid_d;
         irq_q      <= irq_d;
      end
   end

   assign TIMEOUT_IRQ = irq_q;

   logic unused_c;
   assign unused_c = ^{HADDR[REGION_BITS-1:0], HTRANS[0]};
`else
   assign timeout_hit_c = 1'b0;
   assign TIMEOUT_IRQ   = 1'b0;

   logic unused_c;
   assign unused_c = ^{HADDR[REGION_BITS-1:0], HTRANS[0], 1'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect with default parameters; optional AHB_IC_TIMEOUT_EN build.
module tb_ahb_lite_interconnect;

   logic         HCLK = 1'b0;
   logic         HRESET;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic [4:0]   HSEL;
   logic [159:0] HRDATA_S;
   logic [4:0]   HREADYOUT_S;
   logic [4:0]   HRESP_S;
   logic [31:0]  HRDATA;
   logic         HREADY;
   logic         HRESP;
   logic         TIMEOUT_IRQ;

   int tests = 0;
   int fails = 0;

   always #5 HCLK = ~HCLK;

   ahb_lite_interconnect dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL        (HSEL),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .TIMEOUT_IRQ (TIMEOUT_IRQ)
   );

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic mid();
      @(negedge HCLK);
   endtask

   task automatic set_rdata(input int idx, input logic [31:0] v);
      HRDATA_S[idx*32 +: 32] = v;
   endtask

   task automatic test_reset();
      HRESET = 1'b1; HADDR = 32'h9000_0000; HTRANS = 2'b00;
      HREADYOUT_S = 5'b11111; HRESP_S = 5'b00000; HRDATA_S = '0;
      step(); step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL reset_rdy_resp: got %b exp 10", {HREADY, HRESP}); end
      tests++; if (HRDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_rdata: got %h exp deadbeef", HRDATA); end
      tests++; if (TIMEOUT_IRQ !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b exp 0", TIMEOUT_IRQ); end
      tests++; if (HSEL !== 5'b00000) begin fails++; $display("FAIL reset_hsel: got %b exp 00000", HSEL); end
      HRESET = 1'b0;
      step();
   endtask

   task automatic test_slave_wait();
      HADDR = 32'h5100_0004; HTRANS = 2'b10; mid();
      tests++; if (HSEL !== 5'b00010) begin fails++; $display("FAIL wait_hsel: got %b exp 00010", HSEL); end
      tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL wait_addr_rdy: got %b exp 1", HREADY); end
      step();
      HTRANS = 2'b00; HADDR = 32'h9000_0000; HREADYOUT_S[1] = 1'b0; set_rdata(1, 32'hFFFF_FFFF); mid();
      tests++; if (HREADY !== 1'b0) begin fails++; $display("FAIL wait_w1: got %b exp 0", HREADY); end
      step(); mid();
      tests++; if (HREADY !== 1'b0) begin fails++; $display("FAIL wait_w2: got %b exp 0", HREADY); end
      step();
      HREADYOUT_S[1] = 1'b1; set_rdata(1, 32'h0000_0012); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL wait_done: got %b exp 10", {HREADY, HRESP}); end
      tests++; if (HRDATA !== 32'h0000_0012) begin fails++; $display("FAIL wait_rdata: got %h exp 00000012", HRDATA); end
      step();
   endtask

   task automatic test_unmapped();
      HADDR = 32'h9000_0000; HTRANS = 2'b10; mid();
      tests++; if (HSEL !== 5'b00000) begin fails++; $display("FAIL unmap_hsel: got %b exp 00000", HSEL); end
      tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL unmap_addr_rdy: got %b exp 1", HREADY); end
      step();
      HTRANS = 2'b00; mid();
      tests++; if ({HREADY, HRESP} !== 2'b01) begin fails++; $display("FAIL unmap_err1: got %b exp 01", {HREADY, HRESP}); end
      tests++; if (HRDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL unmap_rdata: got %h exp deadbeef", HRDATA); end
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b11) begin fails++; $display("FAIL unmap_err2: got %b exp 11", {HREADY, HRESP}); end
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL unmap_idle_okay: got %b exp 10", {HREADY, HRESP}); end
      HTRANS = 2'b01;
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL unmap_busy_okay: got %b exp 10", {HREADY, HRESP}); end
      HTRANS = 2'b00;
      step();
   endtask

   task automatic test_back_to_back();
      HADDR = 32'h0000_0000; HTRANS = 2'b10; mid();
      tests++; if (HSEL !== 5'b00001) begin fails++; $display("FAIL b2b_hsel0: got %b exp 00001", HSEL); end
      step();
      HADDR = 32'h5400_0000; HTRANS = 2'b10; HREADYOUT_S[0] = 1'b0;
      set_rdata(4, 32'h0000_0044); set_rdata(0, 32'h0000_0000); mid();
      tests++; if (HSEL !== 5'b10000) begin fails++; $display("FAIL b2b_hsel4: got %b exp 10000", HSEL); end
      tests++; if (HREADY !== 1'b0) begin fails++; $display("FAIL b2b_wait: got %b exp 0", HREADY); end
      step();
      HREADYOUT_S[0] = 1'b1; set_rdata(0, 32'h0000_00AA); mid();
      tests++; if ({HREADY, HRDATA} !== {1'b1, 32'h0000_00AA}) begin fails++; $display("FAIL b2b_s0_data: got %b/%h exp 1/000000aa", HREADY, HRDATA); end
      step();
      HTRANS = 2'b00; HADDR = 32'h9000_0000; set_rdata(0, 32'h0000_00BB); mid();
      tests++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'h0000_0044}) begin fails++; $display("FAIL b2b_s4_data: got %b%b/%h exp 10/00000044", HREADY, HRESP, HRDATA); end
      step();
   endtask

   task automatic test_err_chain();
      HADDR = 32'h9000_0000; HTRANS = 2'b10; mid();
      tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL chain_addr_rdy: got %b exp 1", HREADY); end
      step();
      HTRANS = 2'b00; mid();
      tests++; if ({HREADY, HRESP} !== 2'b01) begin fails++; $display("FAIL chain_a_err1: got %b exp 01", {HREADY, HRESP}); end
      step();
      HADDR = 32'hA000_0000; HTRANS = 2'b10; mid();
      tests++; if ({HREADY, HRESP} !== 2'b11) begin fails++; $display("FAIL chain_a_err2: got %b exp 11", {HREADY, HRESP}); end
      step();
      HTRANS = 2'b00; mid();
      tests++; if ({HREADY, HRESP} !== 2'b01) begin fails++; $display("FAIL chain_b_err1: got %b exp 01", {HREADY, HRESP}); end
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b11) begin fails++; $display("FAIL chain_b_err2: got %b exp 11", {HREADY, HRESP}); end
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL chain_okay: got %b exp 10", {HREADY, HRESP}); end
      step();
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      HADDR = 32'h5200_0000; HTRANS = 2'b10; mid();
      tests++; if (HSEL !== 5'b00100) begin fails++; $display("FAIL tmo_hsel: got %b exp 00100", HSEL); end
      step();
      HTRANS = 2'b00; HADDR = 32'h9000_0000; HREADYOUT_S[2] = 1'b0; set_rdata(2, 32'h0000_0022);
`ifdef AHB_IC_TIMEOUT_EN
      for (int c = 0; c < 16; c++) begin
         mid();
         if ({HREADY, HRESP, TIMEOUT_IRQ} !== 3'b000) bad++;
         step();
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL tmo_waits: %0d bad wait cycles exp 0", bad); end
      mid();
      tests++; if ({HREADY, HRESP, TIMEOUT_IRQ} !== 3'b011) begin fails++; $display("FAIL tmo_err1: got %b exp 011", {HREADY, HRESP, TIMEOUT_IRQ}); end
      step(); mid();
      tests++; if ({HREADY, HRESP, TIMEOUT_IRQ} !== 3'b110) begin fails++; $display("FAIL tmo_err2: got %b exp 110", {HREADY, HRESP, TIMEOUT_IRQ}); end
      step(); mid();
      tests++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'hDEADBEEF}) begin fails++; $display("FAIL tmo_after: got %b%b/%h exp 10/deadbeef", HREADY, HRESP, HRDATA); end
      step();
`else
      for (int c = 0; c < 100; c++) begin
         mid();
         if ({HREADY, TIMEOUT_IRQ} !== 2'b00) bad++;
         step();
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL tmo_stall: %0d cycles not stalled exp 0", bad); end
`endif
   endtask

   task automatic test_reset_abort();
      HRESET = 1'b1; HTRANS = 2'b00; HADDR = 32'h9000_0000;
      step(); mid();
      tests++; if ({HREADY, HRESP, TIMEOUT_IRQ} !== 3'b100) begin fails++; $display("FAIL abort_hung: got %b exp 100", {HREADY, HRESP, TIMEOUT_IRQ}); end
      tests++; if (HRDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL abort_rdata: got %h exp deadbeef", HRDATA); end
      HRESET = 1'b0; HREADYOUT_S[2] = 1'b1;
      step();
      HTRANS = 2'b10;
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b01) begin fails++; $display("FAIL abort_err1: got %b exp 01", {HREADY, HRESP}); end
      HTRANS = 2'b00; HRESET = 1'b1;
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL abort_err_dropped: got %b exp 10", {HREADY, HRESP}); end
      HRESET = 1'b0;
      step(); mid();
      tests++; if ({HREADY, HRESP} !== 2'b10) begin fails++; $display("FAIL abort_no_err2: got %b exp 10", {HREADY, HRESP}); end
      step();
   endtask

   initial begin
      test_reset();
      test_slave_wait();
      test_unmapped();
      test_back_to_back();
      test_err_chain();
      test_timeout();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
